imem_loader: RTL and testbench

//  Debug-unit writer for the IF-stage instruction memory. Receives program bytes from the UART RX

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Packs UART bytes MSB-first into words and writes them to IF-stage imem; optional IMEM_LOADER_CHECKSUM_EN adds XOR check.
// Latency: write strobe one cycle after the 4th byte; halt word ends the load (DONE, or CHK when checksum built).
// Backpressure: none; every rx strobe is consumed, including one landing in the WRITE cycle.
module imem_loader #(
  parameter int                NB_REG    = 32,
  parameter int                NB_WIDHT  = 9,
  parameter int                NB_BYTE   = 8,
  parameter logic [NB_REG-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_dunit_w_en,
  output logic [NB_WIDHT-1:0]   o_dunit_addr,
  output logic [NB_REG-1:0]     o_dunit_data,
  output logic                  o_dunit_clk_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [NB_WIDHT-2:0]   o_word_count
);

  localparam logic [NB_WIDHT-1:0] ADDR_LAST = {{(NB_WIDHT-2){1'b1}}, 2'b00};
  localparam int                  NB_SR     = NB_REG - NB_BYTE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [NB_SR-1:0]      sr_q, sr_d;
  logic [NB_WIDHT-1:0]   addr_q, addr_d;
  logic [NB_REG-1:0]     data_q, data_d;
  logic [NB_WIDHT-2:0]   wc_q, wc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]    csum_q, csum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wc_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wc_d    = wc_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_RECV;
          addr_d  = '0;
          wc_d    = '0;
          idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_RECV: begin
        if (i_rx_valid) begin
          sr_d  = {sr_q[NB_SR-NB_BYTE-1:0], i_rx_data};
          idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_rx_data;
`endif
          if (idx_q == 2'd3) begin
            data_d  = {sr_q, i_rx_data};
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        wc_d = wc_q + (NB_WIDHT-1)'(1);
        if (data_q == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // a byte landing in this cycle is already the checksum byte
          state_d = ST_CHK;
          if (i_rx_valid)
            state_d = (i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
`else
          state_d = ST_DONE;
`endif
        end else if (addr_q == ADDR_LAST) begin
          state_d = ST_ERROR;
        end else begin
          addr_d  = addr_q + NB_WIDHT'(4);
          state_d = ST_RECV;
          // idx_q has wrapped to 0, so this byte becomes byte 0 of the next word
          if (i_rx_valid) begin
            sr_d  = {sr_q[NB_SR-NB_BYTE-1:0], i_rx_data};
            idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ i_rx_data;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (i_rx_valid)
          state_d = (i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ST_RECV) || (state_q == ST_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    o_busy = o_busy || (state_q == ST_CHK);
`endif
  end

  assign o_dunit_w_en   = (state_q == ST_WRITE);
  assign o_dunit_addr   = addr_q;
  assign o_dunit_data   = data_q;
  assign o_dunit_clk_en = !o_busy;
  assign o_done         = (state_q == ST_DONE);
  assign o_error        = (state_q == ST_ERROR);
  assign o_word_count   = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: packing, gaps, overflow, reset mid-load, restart, optional checksum.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        w_en, clk_en, busy, done, error;
  logic [8:0]  addr;
  logic [31:0] data;
  logic [7:0]  wc;

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int run = 0;
  int max_run = 0;
  int base = 0;
  int bad = 0;
  logic [8:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];

  imem_loader dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_dunit_w_en(w_en), .o_dunit_addr(addr), .o_dunit_data(data), .o_dunit_clk_en(clk_en),
    .o_busy(busy), .o_done(done), .o_error(error), .o_word_count(wc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en) begin
      log_addr[nwr] = addr;
      log_data[nwr] = data;
      nwr++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w_en"}, {31'd0, w_en}, 32'd0);
    chk({tag, "_addr"}, {23'd0, addr}, 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_clk_en"}, {31'd0, clk_en}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_wc"}, {24'd0, wc}, 32'd0);
  endtask

  initial begin
    // T1: reset, single word plus halt
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("rst");
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_clk_en", {31'd0, clk_en}, 32'd0);
    send_word(32'h20080005, 0);
    chk("t1_lat_w_en", {31'd0, w_en}, 32'd1);
    chk("t1_w0_addr", {23'd0, addr}, 32'h0);
    chk("t1_w0_data", data, 32'h20080005);
    @(negedge clk);
    chk("t1_w_en_single", {31'd0, w_en}, 32'd0);
    send_word(32'hFFFFFFFF, 0);
    chk("t1_w1_w_en", {31'd0, w_en}, 32'd1);
    chk("t1_w1_addr", {23'd0, addr}, 32'h4);
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t5_chk_busy", {31'd0, busy}, 32'd1);
    chk("t5_chk_clk_en", {31'd0, clk_en}, 32'd0);
    send_byte(8'h2D, 1);  // 20^08^00^05^FF^FF^FF^FF
`endif
    repeat (2) @(negedge clk);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_wc", {24'd0, wc}, 32'd2);
    chk("t1_clk_en_done", {31'd0, clk_en}, 32'd1);
    chk("t1_nwr", nwr, 2);
    chk("t1_log0", log_data[0], 32'h20080005);
    chk("t1_log1_addr", {23'd0, log_addr[1]}, 32'h4);
    chk("t1_log1_data", log_data[1], 32'hFFFFFFFF);

    // T2/T6: restart from DONE, gaps, byte in WRITE cycle, start ignored mid-RECV
    pulse_start();
    chk("t6_done_clr", {31'd0, done}, 32'd0);
    chk("t6_wc_clr", {24'd0, wc}, 32'd0);
    base = nwr;
    send_byte(8'h12, 3);
    pulse_start();
    chk("t6_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h34, 0);
    send_byte(8'h56, 20);
    send_byte(8'h78, 5);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 7);
    send_byte(8'hC3, 1);
    send_byte(8'h3C, 13);
    send_byte(8'hFF, 2);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 9);
    send_byte(8'hFF, 4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h08, 2);
`endif
    repeat (3) @(negedge clk);
    chk("t2_nwr", nwr - base, 3);
    chk("t2_w0", log_data[base], 32'h12345678);
    chk("t2_w1", log_data[base+1], 32'hA55AC33C);
    chk("t2_w1_addr", {23'd0, log_addr[base+1]}, 32'h4);
    chk("t2_w2", log_data[base+2], 32'hFFFFFFFF);
    chk("t2_w2_addr", {23'd0, log_addr[base+2]}, 32'h8);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_wc", {24'd0, wc}, 32'd3);
    chk("t2_max_run", max_run, 1);

    // T3: memory overflow without halt
    pulse_start();
    base = nwr;
    for (int i = 0; i < 128; i++) send_word(32'h01000000 + i, 0);
    repeat (3) @(negedge clk);
    chk("t3_nwr", nwr - base, 128);
    chk("t3_error", {31'd0, error}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_wc", {24'd0, wc}, 32'h80);
    chk("t3_addr_hold", {23'd0, addr}, 32'h1FC);
    chk("t3_clk_en", {31'd0, clk_en}, 32'd1);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (log_addr[base+i] !== 9'(i*4) || log_data[base+i] !== 32'h01000000 + i) bad++;
    chk("t3_seq", bad, 0);
    send_word(32'h11223344, 0);
    repeat (3) @(negedge clk);
    chk("t3_no_wrap", nwr - base, 128);
    chk("t3_error_hold", {31'd0, error}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // T5: wrong checksum byte
    pulse_start();
    chk("t5_err_clr", {31'd0, error}, 32'd0);
    send_word(32'h20080005, 0);
    send_word(32'hFFFFFFFF, 0);
    send_byte(8'h00, 2);
    repeat (2) @(negedge clk);
    chk("t5_bad_error", {31'd0, error}, 32'd1);
    chk("t5_bad_done", {31'd0, done}, 32'd0);
`endif

    // T4: reset mid-word
    pulse_start();
    base = nwr;
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("t4");
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    repeat (3) @(negedge clk);
    chk("t4_nwr", nwr - base, 0);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
